diff_core_loader: RTL and testbench

// - Upstream feeder of the diff core. Takes a load command plus a 72-bit data stream (FM or guard words) and

---
 rtl/diff_demo_pkg.sv | 15 +
 rtl/diff_bank_addr_gen.sv | 55 +++++
 rtl/diff_core_loader.sv | 191 +++++++++++++++++++
 tb/tb_diff_core_loader.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_demo_pkg.sv
// Shared types for the diff core loader.
// State encoding and the stream word width.
package diff_demo_pkg;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LOAD,
        LD_LAUNCH,
        LD_RUN,
        LD_DONE
    } loader_state_e;

    localparam int LD_WORD_W = 72;

endpackage

// File: rtl/diff_bank_addr_gen.sv
// Round-robin bank/row counters for the loader.
// o_wrap marks beats whose row address has wrapped past the bank depth.
module diff_bank_addr_gen
    import diff_demo_pkg::*;
#(
    parameter int PE_COL = 4,
    parameter int DEPTH  = 256,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int BW     = (PE_COL > 1) ? $clog2(PE_COL) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_step,
    input  logic [AW-1:0] i_base,
    input  logic [AW-1:0] i_last,
    output logic [BW-1:0] o_bank,
    output logic [AW-1:0] o_addr,
    output logic          o_wrap
);

    logic [BW-1:0] r_bank;
    logic [AW-1:0] r_addr;
    logic          r_wrap;
    logic          w_row_end;
    logic          w_addr_end;

    assign w_row_end  = (r_bank == BW'(PE_COL - 1));
    assign w_addr_end = (r_addr == i_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bank <= '0;
            r_addr <= '0;
            r_wrap <= 1'b0;
        end else if (i_start) begin
            r_bank <= '0;
            r_addr <= i_base;
            r_wrap <= 1'b0;
        end else if (i_step) begin
            if (w_row_end) begin
                r_bank <= '0;
                r_addr <= w_addr_end ? '0 : r_addr + 1'b1;
                r_wrap <= r_wrap | w_addr_end;
            end else begin
                r_bank <= r_bank + 1'b1;
            end
        end
    end

    assign o_bank = r_bank;
    assign o_addr = r_addr;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/diff_core_loader.sv
// Loads FM/guard words round-robin into the diff core banks,
// optionally launches the core, and reports completion.
module diff_core_loader
    import diff_demo_pkg::*;
#(
    parameter int PE_COL   = 4,
    parameter int FM_DEPTH = 256,
    parameter int GD_DEPTH = 256,
    parameter int LEN_W    = 16,
    parameter int FM_AW    = $clog2(FM_DEPTH),
    parameter int GD_AW    = $clog2(GD_DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_target,
    input  logic [15:0]                         cmd_base,
    input  logic [LEN_W-1:0]                    cmd_len,
    input  logic                                cmd_launch,
    input  logic                                cmd_is_diff,
    input  logic [LD_WORD_W-1:0]                s_data,
    input  logic                                s_valid,
    output logic                                s_ready,
    output logic [PE_COL-1:0][FM_AW-1:0]        load_fm_wr_addr,
    output logic [PE_COL-1:0][LD_WORD_W-1:0]    load_fm_din,
    output logic [PE_COL-1:0]                   load_fm_wr_en,
    output logic [PE_COL-1:0][GD_AW-1:0]        load_gd_wr_addr,
    output logic [PE_COL-1:0][LD_WORD_W-1:0]    load_gd_din,
    output logic [PE_COL-1:0]                   load_gd_wr_en,
    output logic                                core_valid,
    input  logic                                core_ready,
    input  logic                                core_finish,
    output logic                                core_is_diff_o,
    output logic                                busy,
    output logic                                done,
    output logic                                addr_err
);

    localparam int AW = (FM_AW > GD_AW) ? FM_AW : GD_AW;
    localparam int BW = (PE_COL > 1) ? $clog2(PE_COL) : 1;

    loader_state_e r_state, w_state_nxt;
    logic          r_tgt, r_launch, r_is_diff;
    logic          r_hold, w_hold_nxt;
    logic          r_addr_err;
    logic [LEN_W-1:0] r_len_m1, r_k;

    logic [PE_COL-1:0][FM_AW-1:0]     r_fm_addr;
    logic [PE_COL-1:0][LD_WORD_W-1:0] r_fm_din;
    logic [PE_COL-1:0]                r_fm_en;
    logic [PE_COL-1:0][GD_AW-1:0]     r_gd_addr;
    logic [PE_COL-1:0][LD_WORD_W-1:0] r_gd_din;
    logic [PE_COL-1:0]                r_gd_en;

    logic          w_accept, w_beat, w_last, w_wrap;
    logic [BW-1:0] w_bank;
    logic [AW-1:0] w_addr, w_base, w_last_addr;
    logic          w_unused_base;

    assign cmd_ready   = rst_n && (r_state == LD_IDLE);
    assign s_ready     = (r_state == LD_LOAD);
    assign busy        = (r_state != LD_IDLE);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_beat      = s_valid && s_ready;
    assign w_last      = (r_k == r_len_m1);
    assign w_base      = cmd_target ? AW'(cmd_base[GD_AW-1:0])
                                    : AW'(cmd_base[FM_AW-1:0]);
    assign w_last_addr = r_tgt ? AW'(GD_DEPTH - 1) : AW'(FM_DEPTH - 1);
    assign w_unused_base = &{1'b0, cmd_base};

    assign core_is_diff_o = r_is_diff && (r_state == LD_LAUNCH ||
                            r_state == LD_RUN || r_state == LD_DONE);

    diff_bank_addr_gen #(
        .PE_COL (PE_COL),
        .DEPTH  (1 << AW),
        .AW     (AW),
        .BW     (BW)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(w_accept),
        .i_step (w_beat),
        .i_base (w_base),
        .i_last (w_last_addr),
        .o_bank (w_bank),
        .o_addr (w_addr),
        .o_wrap (w_wrap)
    );

    // Local completions spend one extra DONE cycle so the last write lands first.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = 1'b0;
        core_valid  = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            LD_IDLE: begin
                if (w_accept) begin
                    if (cmd_len != '0) begin
                        w_state_nxt = LD_LOAD;
                    end else if (cmd_launch) begin
                        w_state_nxt = LD_LAUNCH;
                    end else begin
                        w_state_nxt = LD_DONE;
                        w_hold_nxt  = 1'b1;
                    end
                end
            end
            LD_LOAD: begin
                if (w_beat && w_last) begin
                    if (r_launch) begin
                        w_state_nxt = LD_LAUNCH;
                    end else begin
                        w_state_nxt = LD_DONE;
                        w_hold_nxt  = 1'b1;
                    end
                end
            end
            LD_LAUNCH: begin
                core_valid = 1'b1;
                if (core_ready) w_state_nxt = LD_RUN;
            end
            LD_RUN: begin
                if (core_finish) w_state_nxt = LD_DONE;
            end
            LD_DONE: begin
                if (!r_hold) begin
                    done        = 1'b1;
                    w_state_nxt = LD_IDLE;
                end
            end
            default: w_state_nxt = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= LD_IDLE;
            r_hold     <= 1'b0;
            r_tgt      <= 1'b0;
            r_launch   <= 1'b0;
            r_is_diff  <= 1'b0;
            r_addr_err <= 1'b0;
            r_len_m1   <= '0;
            r_k        <= '0;
            r_fm_addr  <= '0;
            r_fm_din   <= '0;
            r_fm_en    <= '0;
            r_gd_addr  <= '0;
            r_gd_din   <= '0;
            r_gd_en    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_fm_en <= '0;
            r_gd_en <= '0;
            if (w_accept) begin
                r_tgt      <= cmd_target;
                r_launch   <= cmd_launch;
                r_is_diff  <= cmd_is_diff;
                r_len_m1   <= cmd_len - 1'b1;
                r_k        <= '0;
                r_addr_err <= 1'b0;
            end
            if (w_beat) begin
                r_k <= r_k + 1'b1;
                if (w_wrap) r_addr_err <= 1'b1;
                if (r_tgt) begin
                    r_gd_en[w_bank]   <= 1'b1;
                    r_gd_addr[w_bank] <= w_addr[GD_AW-1:0];
                    r_gd_din[w_bank]  <= s_data;
                end else begin
                    r_fm_en[w_bank]   <= 1'b1;
                    r_fm_addr[w_bank] <= w_addr[FM_AW-1:0];
                    r_fm_din[w_bank]  <= s_data;
                end
            end
        end
    end

    assign load_fm_wr_addr = r_fm_addr;
    assign load_fm_din     = r_fm_din;
    assign load_fm_wr_en   = r_fm_en;
    assign load_gd_wr_addr = r_gd_addr;
    assign load_gd_din     = r_gd_din;
    assign load_gd_wr_en   = r_gd_en;
    assign addr_err        = r_addr_err;

endmodule

// File: tb/tb_diff_core_loader.sv
// Bench for diff_core_loader: command table driven through a write
// scoreboard, plus launch handshake and mid-load reset sequences.
module tb_diff_core_loader;
    import diff_demo_pkg::*;

    localparam int PE = 4;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic cmd_target = 1'b0;
    logic [15:0] cmd_base = '0;
    logic [LW-1:0] cmd_len = '0;
    logic cmd_launch = 1'b0;
    logic cmd_is_diff = 1'b0;
    logic [LD_WORD_W-1:0] s_data = '0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic [PE-1:0][7:0] fm_addr, gd_addr;
    logic [PE-1:0][71:0] fm_din, gd_din;
    logic [PE-1:0] fm_en, gd_en;
    logic core_valid;
    logic core_ready = 1'b0;
    logic core_finish = 1'b0;
    logic core_is_diff_o, busy, done, addr_err;

    diff_core_loader #(
        .PE_COL  (PE),
        .FM_DEPTH(256),
        .GD_DEPTH(256),
        .LEN_W   (LW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_target     (cmd_target),
        .cmd_base       (cmd_base),
        .cmd_len        (cmd_len),
        .cmd_launch     (cmd_launch),
        .cmd_is_diff    (cmd_is_diff),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .load_fm_wr_addr(fm_addr),
        .load_fm_din    (fm_din),
        .load_fm_wr_en  (fm_en),
        .load_gd_wr_addr(gd_addr),
        .load_gd_din    (gd_din),
        .load_gd_wr_en  (gd_en),
        .core_valid     (core_valid),
        .core_ready     (core_ready),
        .core_finish    (core_finish),
        .core_is_diff_o (core_is_diff_o),
        .busy           (busy),
        .done           (done),
        .addr_err       (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tgt;
        logic [15:0] base;
        int          len;
        logic        launch;
        logic        is_diff;
        logic        bubble;
    } vec_t;

    typedef struct {
        logic        tgt;
        int          bank;
        int          addr;
        logic [71:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   fm_cnt = 0;
    int   gd_cnt = 0;
    bit   mon_en = 0;
    logic prev_err = 1'b0;

    task automatic chk(input string nm, input logic [71:0] act,
                       input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] mkd(input int id, input int k);
        return {8'(id), 32'hC0DE_0000, 32'(k)};
    endfunction

    task automatic take(input logic tgt, input int b, input logic [7:0] a,
                        input logic [71:0] d);
        wr_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL stray_wr: tgt %0d bank %0d addr %0h, no write expected",
                     tgt, b, a);
            return;
        end
        e = exp_q.pop_front();
        chk("wr_tgt", tgt, e.tgt);
        chk("wr_bank", b, e.bank);
        chk("wr_addr", a, e.addr);
        chk("wr_data", d, e.data);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if ($countones({fm_en, gd_en}) > 1)
                chk("onehot_wr", $countones({fm_en, gd_en}), 1);
            for (int b = 0; b < PE; b++) begin
                if (fm_en[b]) begin
                    fm_cnt++;
                    take(1'b0, b, fm_addr[b], fm_din[b]);
                end
                if (gd_en[b]) begin
                    gd_cnt++;
                    take(1'b1, b, gd_addr[b], gd_din[b]);
                end
            end
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_core_valid"}, core_valid, 0);
        chk({tag, "_is_diff"}, core_is_diff_o, 0);
        chk({tag, "_addr_err"}, addr_err, 0);
        chk({tag, "_wr_en"}, {fm_en, gd_en}, 0);
        chk({tag, "_wr_bus"}, 72'(|{fm_addr, fm_din, gd_addr, gd_din}), 0);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int k, lat, sr_hi, cv_cnt, cv_first;
        logic exp_err;
        logic [7:0] b8;
        k = 0;
        lat = 0;
        sr_hi = 0;
        cv_cnt = 0;
        cv_first = 0;
        b8 = v.base[7:0];
        exp_err = (v.len > 0) && ((int'(b8) + (v.len - 1) / PE) > 255);
        fm_cnt = 0;
        gd_cnt = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_target = v.tgt;
        cmd_base = v.base;
        cmd_len = LW'(v.len);
        cmd_launch = v.launch;
        cmd_is_diff = v.is_diff;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        chk("err_held", addr_err, prev_err);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 64 && k < v.len; c++) begin
            s_valid = v.bubble ? (c % 2 == 0) : 1'b1;
            s_data = mkd(id, k);
            @(negedge clk);
            if (c == 0) begin
                chk("err_clr", addr_err, 0);
                chk("s_ready_first", s_ready, 1);
            end
            if (s_valid && s_ready) begin
                exp_q.push_back('{v.tgt, k % PE, (int'(b8) + k / PE) % 256,
                                  mkd(id, k)});
                k++;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("beats", k, v.len);
        if (v.launch) begin
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (i == 1 && v.len == 0) chk("err_clr", addr_err, 0);
                if (s_ready) sr_hi++;
                if (core_valid) begin
                    if (cv_cnt == 0) cv_first = i;
                    cv_cnt++;
                    chk("is_diff", core_is_diff_o, v.is_diff);
                    if (cv_cnt == 4) begin
                        core_ready = 1'b1;
                        core_finish = 1'b1;
                    end
                end else if (cv_cnt > 0) begin
                    break;
                end
            end
            core_ready = 1'b0;
            core_finish = 1'b0;
            chk("launch_lat", cv_first, 1);
            chk("cv_cycles", cv_cnt, 4);
            for (int i = 0; i < 3; i++) begin
                chk("run_no_done", done, 0);
                chk("run_busy", busy, 1);
                @(negedge clk);
            end
            core_finish = 1'b1;
        end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                core_finish = 1'b0;
                if (v.len == 0 && !v.launch) chk("err_clr", addr_err, 0);
            end
            if (s_ready) sr_hi++;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("done_lat", lat, v.launch ? 1 : 2);
        chk("s_ready_after", sr_hi, 0);
        chk("addr_err", addr_err, exp_err);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        chk("q_empty", exp_q.size(), 0);
        chk("fm_writes", fm_cnt, v.tgt ? 0 : v.len);
        chk("gd_writes", gd_cnt, v.tgt ? v.len : 0);
        prev_err = exp_err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];
        int k;
        tbl[0] = '{1'b0, 16'd8,     10, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 16'd40,     5, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 16'd100,    4, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 16'd255,    8, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'd0,      0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 16'h1203,   7, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 16'd0,      0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 16'd254,   12, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("init");
        mon_en = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_ready", cmd_ready, 1);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_target = 1'b0;
        cmd_base = 16'd0;
        cmd_len = LW'(10);
        cmd_launch = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && k < 3; c++) begin
            s_valid = 1'b1;
            s_data = mkd(99, k);
            @(negedge clk);
            if (s_valid && s_ready) begin
                exp_q.push_back('{1'b0, k % PE, k / PE, mkd(99, k)});
                k++;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_outs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", cmd_ready, 1);
        chk("rel_wr_en", {fm_en, gd_en}, 0);
        chk("rel_busy", busy, 0);
        chk("rel_q_empty", exp_q.size(), 0);
        prev_err = 1'b0;

        run_vec(tbl[0], 9);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
